// File: rtl/decode_pkg.sv
// Shared types for the addressing-byte sequencer.
// State encoding, mod/rm codes and the packed addressing record.
package decode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MODRM,
        SIB,
        DISP,
        DONE
    } state_e;

    localparam logic [1:0] MOD_REG       = 2'b11;
    localparam logic [2:0] RM_SIB        = 3'b100;
    localparam logic [2:0] RM_DISP16     = 3'b110;
    localparam logic [2:0] RM_DISP32     = 3'b101;
    localparam logic [2:0] SIB_BASE_NONE = 3'b101;

    typedef struct packed {
        logic [1:0]  mod;
        logic [2:0]  regf;
        logic [2:0]  rm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [2:0]  disp_len;
        logic [31:0] disp;
    } addr_rec_t;

    // Sign-extend an n-byte little-endian displacement to 32 bits.
    function automatic logic [31:0] sext_disp(input logic [31:0] v,
                                              input logic [2:0]  n);
        case (n)
            3'd1:    return {{24{v[7]}}, v[7:0]};
            3'd2:    return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/decode_disp_len.sv
// Displacement byte count from mod/rm (and s-i-b base when present).
// Purely combinational; shared with the instruction-length decoder.
module decode_disp_len
    import decode_pkg::*;
(
    input  logic       addr_32_i,
    input  logic [1:0] mod_i,
    input  logic [2:0] rm_i,
    input  logic [2:0] sib_base_i,
    input  logic       sib_present_i,
    output logic [2:0] disp_len_o
);

    // Map addressing form to 0/1/2/4 displacement bytes.
    always_comb begin
        disp_len_o = 3'd0;
        if (addr_32_i) begin
            case (mod_i)
                2'b00: begin
                    if (rm_i == RM_DISP32 ||
                        (sib_present_i && sib_base_i == SIB_BASE_NONE))
                        disp_len_o = 3'd4;
                end
                2'b01:   disp_len_o = 3'd1;
                2'b10:   disp_len_o = 3'd4;
                default: disp_len_o = 3'd0;
            endcase
        end else begin
            case (mod_i)
                2'b00: begin
                    if (rm_i == RM_DISP16)
                        disp_len_o = 3'd2;
                end
                2'b01:   disp_len_o = 3'd1;
                2'b10:   disp_len_o = 3'd2;
                default: disp_len_o = 3'd0;
            endcase
        end
    end

endmodule

// File: rtl/decode_addr_seq.sv
// Walks mod r/m, s-i-b and displacement bytes into one addressing record.
// Optional SS-default output: define DECODE_ADDR_SEQ_SEG_EN.
module decode_addr_seq
    import decode_pkg::*;
#(
    parameter int DISP_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic              addr_32,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_mod,
    output logic [2:0]        out_reg,
    output logic [2:0]        out_rm,
    output logic              out_has_sib,
    output logic [7:0]        out_sib,
    output logic [2:0]        out_disp_len,
    output logic [DISP_W-1:0] out_disp,
    output logic [CNT_W-1:0]  out_len,
    output logic              busy
`ifdef DECODE_ADDR_SEQ_SEG_EN
    ,
    output logic              out_seg_ss
`endif
);

    state_e             state_q, state_d;
    addr_rec_t          rec_q, rec_d;
    logic               a32_q, a32_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [1:0]         dcnt_q, dcnt_d;
    logic               hs;
    logic [1:0]         dl_mod;
    logic [2:0]         dl_rm;
    logic [2:0]         dl;
    logic [31:0]        raw;

    assign dl_mod = (state_q == MODRM) ? byte_data[7:6] : rec_q.mod;
    assign dl_rm  = (state_q == MODRM) ? byte_data[2:0] : rec_q.rm;

    decode_disp_len u_dlen (
        .addr_32_i     (a32_q),
        .mod_i         (dl_mod),
        .rm_i          (dl_rm),
        .sib_base_i    (byte_data[2:0]),
        .sib_present_i (state_q == SIB),
        .disp_len_o    (dl)
    );

    assign byte_ready = !flush && (state_q == MODRM || state_q == SIB ||
                                   state_q == DISP);
    assign hs         = byte_valid && byte_ready;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);

    assign out_mod      = rec_q.mod;
    assign out_reg      = rec_q.regf;
    assign out_rm       = rec_q.rm;
    assign out_has_sib  = rec_q.has_sib;
    assign out_sib      = rec_q.sib;
    assign out_disp_len = rec_q.disp_len;
    assign out_disp     = DISP_W'($signed(rec_q.disp));
    assign out_len      = len_q;

`ifdef DECODE_ADDR_SEQ_SEG_EN
    // SS is the default segment when the base register is BP/EBP/ESP.
    always_comb begin
        out_seg_ss = 1'b0;
        if (rec_q.mod != MOD_REG) begin
            if (a32_q)
                out_seg_ss = (rec_q.rm == RM_DISP32 && rec_q.mod != 2'b00) ||
                             (rec_q.has_sib && rec_q.sib[2:0] == 3'b100) ||
                             (rec_q.has_sib && rec_q.sib[2:0] == 3'b101 &&
                              rec_q.mod != 2'b00);
            else
                out_seg_ss = rec_q.rm == 3'b010 || rec_q.rm == 3'b011 ||
                             (rec_q.rm == RM_DISP16 && rec_q.mod != 2'b00);
        end
    end
`endif

    // Next-state and record update; flush overrides everything.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        a32_d   = a32_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        raw     = rec_q.disp;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rec_d   = '0;
                        a32_d   = addr_32;
                        len_d   = '0;
                        dcnt_d  = '0;
                        state_d = MODRM;
                    end
                end
                MODRM: begin
                    if (hs) begin
                        rec_d.mod  = byte_data[7:6];
                        rec_d.regf = byte_data[5:3];
                        rec_d.rm   = byte_data[2:0];
                        len_d      = CNT_W'(1);
                        if (a32_q && byte_data[7:6] != MOD_REG &&
                            byte_data[2:0] == RM_SIB) begin
                            state_d = SIB;
                        end else begin
                            rec_d.disp_len = dl;
                            state_d = (dl != 3'd0) ? DISP : DONE;
                        end
                    end
                end
                SIB: begin
                    if (hs) begin
                        rec_d.has_sib  = 1'b1;
                        rec_d.sib      = byte_data;
                        rec_d.disp_len = dl;
                        len_d          = len_q + CNT_W'(1);
                        state_d = (dl != 3'd0) ? DISP : DONE;
                    end
                end
                DISP: begin
                    if (hs) begin
                        raw[{dcnt_q, 3'b000} +: 8] = byte_data;
                        len_d  = len_q + CNT_W'(1);
                        dcnt_d = dcnt_q + 2'd1;
                        if ({1'b0, dcnt_q} == rec_q.disp_len - 3'd1) begin
                            rec_d.disp = sext_disp(raw, rec_q.disp_len);
                            state_d    = DONE;
                        end else begin
                            rec_d.disp = raw;
                        end
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rec_q   <= '0;
            a32_q   <= 1'b0;
            len_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            a32_q   <= a32_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
        end
    end

    a_len_max: assert property (@(posedge clk) disable iff (!rst_n)
        len_q <= CNT_W'(6));

    a_dcnt_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == DISP |-> {1'b0, dcnt_q} < rec_q.disp_len);

endmodule

// File: doc/decode_addr_seq.md
Name: decode_addr_seq

Overview:
- Sequencer that walks the addressing bytes (mod r/m, optional s-i-b, 0/1/2/4-byte displacement) following the primary opcode.
- Pulls bytes one per cycle from the prefetch byte stream.
- Emits one packed addressing record per instruction to the mod/rm field decoder and the EA datapath.
- Sits between the prefetch queue and the decode stage; the opcode decoder launches it with `start`.

Parameters:
- DISP_W, 32, width of the sign-extended displacement output (must be >= 32).
- CNT_W, 3, width of the consumed-byte counter (max 6 bytes: modrm + sib + 4 disp).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns the block to IDLE
- start  in  1  opcode decoder requests addressing decode (sampled only in IDLE)
- addr_32  in  1  address size for this instruction: 1 = 32-bit, 0 = 16-bit (latched on start)
- byte_valid  in  1  prefetch byte available
- byte_data  in  8  prefetch byte
- byte_ready  out  1  byte consumed this cycle when byte_valid & byte_ready
- out_valid  out  1  addressing record valid
- out_ready  in  1  downstream accepts record
- out_mod  out  2  mod field
- out_reg  out  3  reg/TTT field
- out_rm  out  3  r/m field
- out_has_sib  out  1  s-i-b byte present
- out_sib  out  8  s-i-b byte (0 when absent)
- out_disp_len  out  3  displacement bytes: 0, 1, 2 or 4
- out_disp  out  DISP_W  displacement, sign-extended from out_disp_len bytes
- out_len  out  CNT_W  total addressing bytes consumed (1..6)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all outputs 0, including byte_ready, out_valid, busy and every record field.
- States and transitions:
  - IDLE: byte_ready = 0. On start, clear the record, latch addr_32, go to MODRM. start is ignored in any other state.
  - MODRM: byte_ready = 1. On a handshake, latch mod/reg/rm and set len = 1. Then:
    - SIB needed when addr_32 & mod != 11 & rm == 100 → go to SIB.
    - Otherwise compute disp_len; go to DISP if nonzero, else DONE.
  - SIB: on a handshake, latch sib, len += 1, compute disp_len; go to DISP if nonzero, else DONE.
  - DISP: on each handshake, shift the byte into disp little-endian (byte k → bits 8k+7:8k), len += 1. After the final byte, sign-extend from bit 8·disp_len-1 and go to DONE.
  - DONE: out_valid = 1, record held stable. On out_valid & out_ready → IDLE. byte_ready = 0.
- Displacement length, 16-bit (addr_32 = 0):
  - mod 00 & rm 110 → 2
  - mod 01 → 1
  - mod 10 → 2
  - all other cases → 0
- Displacement length, 32-bit (addr_32 = 1):
  - mod 00 & rm 101 → 4
  - mod 00 & sib.base == 101 → 4
  - mod 01 → 1
  - mod 10 → 4
  - mod 11 → 0
  - all other mod 00 cases → 0
- Throughput:
  - Latency from the last consumed byte to out_valid is one cycle.
  - Minimum instruction time is byte count + 1 cycles plus the DONE handshake; no back-to-back overlap.
- byte_valid low: state holds, no counter or shift change, no timeout.
- out_ready low in DONE: record held indefinitely; byte_ready stays 0 (no over-consumption).
- flush: highest priority after reset. Next state = IDLE, out_valid drops next cycle, the byte presented in that cycle is not consumed (byte_ready forced 0 while flush is high).
- flush and start in the same cycle: flush wins, start is dropped.
- out_len never exceeds 6; a displacement byte counter that overflows in DISP is a design error (SVA assertion).

Optional Feature:
- Macro: DECODE_ADDR_SEQ_SEG_EN.
- When defined, adds output port `out_seg_ss` (1 bit): default segment is SS, valid with out_valid.
  - 16-bit: set when rm 010/011, or when mod 01/10 & rm 110.
  - 32-bit: set when the base register is EBP or ESP (rm 101 with mod 01/10, or sib.base 100, or sib.base 101 with mod != 00).
  - Cleared for mod 11.
- When undefined, the port and its logic are absent; downstream assumes DS.

Decomposition:
- Shared package `decode_pkg`:
  - state enum (IDLE, MODRM, SIB, DISP, DONE)
  - constants for mod/rm codes (MOD_REG = 2'b11, RM_SIB = 3'b100, RM_DISP16 = 3'b110, RM_DISP32 = 3'b101, SIB_BASE_NONE = 3'b101)
  - packed struct for the addressing record
- One natural sub-module: `decode_disp_len`, purely combinational (addr_32, mod, rm, sib_base, sib_present → disp_len). It is reused by the instruction-length decoder.

Test Plan:
- 16-bit, start, bytes 0x46, 0xF0 → out_mod = 01, out_rm = 110, out_disp_len = 1, out_disp = 0xFFFF_FFF0, out_len = 2, out_has_sib = 0; with the macro, out_seg_ss = 1.
- 32-bit, bytes 0x04, 0x25, 0x78, 0x56, 0x34, 0x12 → out_has_sib = 1, out_sib = 0x25, out_disp_len = 4, out_disp = 0x1234_5678, out_len = 6.
- 32-bit, byte 0xC3 → out_mod = 11, out_rm = 011, out_reg = 000, out_disp_len = 0, out_len = 1; out_valid asserted the cycle after the handshake.
- 16-bit, bytes 0x86, 0x34, 0x12:
  - byte_valid low 3 cycles between 0x34 and 0x12 → state holds, out_disp = 0x0000_1234.
  - then out_ready low 5 cycles → record stable and byte_ready = 0 throughout.
- Mid-DISP of a 4-byte displacement:
  - flush → IDLE next cycle, byte_ready = 0 in the flush cycle, next start decodes cleanly.
  - same mid-DISP point with rst_n asserted asynchronously → all outputs 0 immediately.
